// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared encodings for the processor memory interface
package mem_if_pkg;

    localparam logic [1:0] CMD_NONE      = 2'd0;
    localparam logic [1:0] CMD_READ      = 2'd1;
    localparam logic [1:0] CMD_WRITE     = 2'd2;
    localparam logic [1:0] CMD_INTERRUPT = 2'd3;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_bram_dp.sv
// rtl/mem_bram_dp.sv - dual-port RAM, byte-write port A, read-only port B, read-first
module mem_bram_dp #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr_i,
    input  logic [3:0]    a_we_i,
    input  logic [31:0]   a_wdata_i,
    output logic [31:0]   a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [31:0]   b_rdata_o
);

    logic [31:0] mem [DEPTH];

    // Outputs are left unreset so synthesis can map them onto BRAM output registers.
    always_ff @(posedge clk) begin
        a_rdata_o <= mem[a_addr_i];
        for (int i = 0; i < 4; i++) begin
            if (a_we_i[i]) begin
                mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        b_rdata_o <= mem[b_addr_i];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder: data FSM, instruction fetch port, start announce
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int          DEPTH       = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] START_ADDR  = 32'h0000_0000,
    parameter int          START_DELAY = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  command,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        ready,
    output logic [31:0] data_rdata,
    output logic [1:0]  error,
    output logic        interrupt_ack,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        mem_start_ready,
    output logic [31:0] mem_start
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(START_DELAY + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     cmd_q;
    logic [29:0]    word_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic [31:0]    rdata_q;
    logic [1:0]     error_q;
    logic           ack_q;
    logic           inst_valid_q;
    logic [SW-1:0]  st_cnt_q;

    logic           accept;
    logic           complete;
    logic           in_range;
    logic [AW-1:0]  a_addr;
    logic [3:0]     a_we;
    logic [31:0]    a_rdata;
    logic [31:0]    b_rdata;
    logic           unused_bits;

    assign unused_bits = ^{data_addr[1:0], inst_addr[1:0]};

    assign in_range = (word_q[29:AW] == '0);
    // While idle, port A tracks the live address so the word is already read by the accept edge.
    assign a_addr   = (state_q == ST_IDLE) ? data_addr[AW+1:2] : word_q[AW-1:0];
    assign a_we     = (complete && cmd_q == CMD_WRITE && in_range) ? wstrb_q : 4'b0000;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (command != CMD_NONE) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (command == CMD_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= CMD_NONE;
            word_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            error_q <= ERR_NONE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= complete && (cmd_q == CMD_INTERRUPT);
            if (accept) begin
                cmd_q   <= command;
                word_q  <= data_addr[31:2];
                wdata_q <= data_wdata;
                wstrb_q <= data_wstrb;
                error_q <= ERR_NONE;
            end
            if (complete) begin
                if (cmd_q != CMD_INTERRUPT && !in_range) begin
                    rdata_q <= '0;
                    error_q <= ERR_RANGE;
                end else begin
                    error_q <= ERR_NONE;
                    if (cmd_q == CMD_READ) begin
                        rdata_q <= a_rdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid_q <= 1'b0;
            st_cnt_q     <= '0;
        end else begin
            inst_valid_q <= (inst_addr[31:AW+2] == '0);
            if (st_cnt_q != SW'(START_DELAY)) begin
                st_cnt_q <= st_cnt_q + 1'b1;
            end
        end
    end

    mem_bram_dp #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk       (clk),
        .a_addr_i  (a_addr),
        .a_we_i    (a_we),
        .a_wdata_i (wdata_q),
        .a_rdata_o (a_rdata),
        .b_addr_i  (inst_addr[AW+1:2]),
        .b_rdata_o (b_rdata)
    );

    assign ready           = (state_q != ST_BUSY);
    assign data_rdata      = rdata_q;
    assign error           = error_q;
    assign interrupt_ack   = ack_q;
    assign inst_rdata      = inst_valid_q ? b_rdata : 32'h0;
    assign mem_start_ready = (st_cnt_q == SW'(START_DELAY));
    assign mem_start       = START_ADDR;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor data/instruction interface: it answers `command`/`data_addr`/`data_wdata`/`data_wstrb` with `ready`/`data_rdata`/`error`/`interrupt_ack`.
- Serves instruction fetches on a second port.
- Announces the program start address via `mem_start_ready`/`mem_start`.
- Sits opposite the processor wrapper in simulation and FPGA top levels; backed by on-chip dual-port RAM.

Parameters:
- DEPTH, 4096, RAM size in 32-bit words (power of two).
- LATENCY, 2, cycles `ready` stays low after a request is accepted (>=1).
- START_ADDR, 32'h0000_0000, value driven on `mem_start`.
- START_DELAY, 16, cycles after reset release before `mem_start_ready` rises (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- command  input  2  request: 0 none, 1 read, 2 write, 3 interrupt.
- data_addr  input  32  byte address of data access; bits [1:0] ignored.
- data_wdata  input  32  write data.
- data_wstrb  input  4  byte enables for write; bit i covers byte [8i+7:8i].
- ready  output  1  high = idle/complete; low = busy.
- data_rdata  output  32  read result, valid while ready=1 after a read.
- error  output  2  0 ok, 1 address out of range, 2/3 reserved (never driven).
- interrupt_ack  output  1  one-cycle pulse completing command 3.
- inst_addr  input  32  instruction fetch byte address (word aligned).
- inst_rdata  output  32  instruction word.
- mem_start_ready  output  1  start address valid.
- mem_start  output  32  program start address.

Behaviour:
- Reset values (async, rst_n=0):
  - ready=1, data_rdata=0, error=0, interrupt_ack=0, inst_rdata=0, mem_start_ready=0, mem_start=START_ADDR.
  - FSM=IDLE, counters cleared.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE, ready=1:
  - Accept at any edge where command!=0; latch command, word address (`data_addr[31:2]`), wdata, wstrb.
  - Go to BUSY with countdown=LATENCY-1.
- BUSY, ready=0:
  - Decrement each cycle.
  - At the edge where countdown==0, perform the operation and go to DONE.
  - Input changes during BUSY are ignored.
- Operation at the completion edge:
  - Read: data_rdata<=RAM[word], error<=0.
  - Write: RAM bytes with wstrb set are updated, error<=0, data_rdata unchanged.
  - Interrupt: no RAM access, error<=0, interrupt_ack<=1 for exactly one cycle.
  - Out of range (word >= DEPTH, read or write): no RAM write, data_rdata<=0, error<=1.
- Timing: ready is low for exactly LATENCY cycles after the accept edge; results are valid from the first ready=1 cycle.
- DONE, ready=1:
  - Holds data_rdata/error until command==0 observed, then IDLE.
  - A command held nonzero is never re-accepted; the processor must return command to 0 between requests.
  - error clears to 0 on the next accepted request, not on return to IDLE.
- Write with wstrb=0: completes normally, no RAM change.
- Instruction port:
  - inst_rdata<=RAM[inst_addr[31:2]] every cycle (1-cycle registered latency, independent of FSM).
  - Out-of-range fetch returns 0.
- Collision: fetch and data write to the same word on the same edge → inst_rdata returns old data (read-first).
- Start counter:
  - Counts START_DELAY cycles after reset release; then mem_start_ready=1 and stays 1 until reset.
  - mem_start constant START_ADDR.
- Reset mid-operation: a request in BUSY is aborted with no RAM write; ready=1 immediately on reset assertion.

Decomposition:
- Package mem_if_pkg:
  - Command encodings: CMD_NONE=0, CMD_READ=1, CMD_WRITE=2, CMD_INTERRUPT=3.
  - Error codes: ERR_NONE=0, ERR_RANGE=1.
  - FSM state enum.
- Sub-module mem_bram_dp:
  - True dual-port RAM, 32-bit words, per-byte write enable.
  - Port A read/write, port B read-only, both registered read, read-first.
  - Inferable as BRAM.

Test Plan:
- Reset release with START_DELAY=16 → mem_start_ready=0 for 16 cycles, then 1 with mem_start=0x00000000.
- Write 0xDEADBEEF to 0x40 with wstrb=4'hF, LATENCY=2 → ready low 2 cycles then high, error=0; read 0x40 → data_rdata=0xDEADBEEF.
- Write 0x000000AA with wstrb=4'b0001 to 0x40 (holding 0xDEADBEEF) → read returns 0xDEADBEAA; read of 0x42 returns the same word.
- Read addr=DEPTH*4 (0x4000) → error=1, data_rdata=0, RAM untouched; next valid read → error=0.
- command=3 → interrupt_ack high exactly one cycle, coincident with ready rising. Command held at 3 for 10 more cycles → no second ack and ready stays 1; command=0 then 3 → second ack.
- Assert rst_n=0 during BUSY of a write to 0x80 → ready=1 immediately; subsequent read of 0x80 returns the prior value.
